// File: rtl/uart_pkg.sv
// Shared UART constants: line levels, frame state encoding and the parity helper.
// The transmitter uses these now; the receiver will move onto them later.
package uart_pkg;

    // Line levels for the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame state; each state names the bit currently being driven on the line
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity bit for one data byte; odd=0 gives even parity, odd=1 gives odd parity
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bclk_rise.sv
// Rising-edge detector for the baud generator's bit clock, sampled in the clk domain.
// was_bclk clears on reset, so a bclk already high at reset release yields one brise.
module uart_bclk_rise (
    input  logic clk,
    input  logic rst,
    input  logic bclk,
    output logic brise
);

    logic was_bclk;

    // Remember last cycle's bclk level so a rising edge is seen exactly once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            was_bclk <= 1'b0;
        end else begin
            was_bclk <= bclk;
        end
    end

    assign brise = bclk && !was_bclk;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding an LSB-first shift register,
// optional parity bit and 1 or 2 stop bits. Frames advance only on bclk rising edges.
//
// Input handshake: a byte is accepted on any posedge clk where din_vld && din_rdy;
// din_rdy is high whenever the holding register is empty, in any frame state.
// din_vld may be dropped or din changed freely while din_rdy is low.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic       ODD_SEL   = (PARITY_ODD != 0);
    localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

    logic        brise;
    uart_state_e state;
    logic [7:0]  hold;
    logic        hold_full;
    logic [7:0]  shift;
    logic        par;
    logic [2:0]  bit_ctr;
    logic [0:0]  stop_ctr;

    uart_bclk_rise u_bclk_rise (
        .clk   (clk),
        .rst   (rst),
        .bclk  (bclk),
        .brise (brise)
    );

    assign din_rdy = !hold_full;
    assign busy    = (state != IDLE);

    // Holding register plus frame FSM; tx and done are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= STOP_BIT;
            done      <= 1'b0;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shift     <= 8'h00;
            par       <= 1'b0;
            bit_ctr   <= 3'd0;
            stop_ctr  <= 1'b0;
        end else begin
            done <= 1'b0;

            // Accept can never coincide with a load: load needs hold_full, accept needs it clear
            if (din_vld && !hold_full) begin
                hold      <= din;
                hold_full <= 1'b1;
            end

            if (brise) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            shift     <= hold;
                            par       <= parity_bit(hold, ODD_SEL);
                            hold_full <= 1'b0;
                            tx        <= START_BIT;
                            state     <= START;
                        end else begin
                            tx <= STOP_BIT;
                        end
                    end
                    START: begin
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_ctr <= 3'd0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_ctr != 3'd7) begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_ctr <= bit_ctr + 3'd1;
                        end else if (PARITY_EN != 0) begin
                            tx    <= par;
                            state <= PARITY;
                        end else begin
                            tx       <= STOP_BIT;
                            stop_ctr <= 1'b0;
                            state    <= STOP;
                        end
                    end
                    PARITY: begin
                        tx       <= STOP_BIT;
                        stop_ctr <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (stop_ctr != STOP_LAST) begin
                            stop_ctr <= stop_ctr + 1'b1;
                        end else begin
                            done <= 1'b1;
                            // Queued byte starts immediately: no idle bit between frames
                            if (hold_full) begin
                                shift     <= hold;
                                par       <= parity_bit(hold, ODD_SEL);
                                hold_full <= 1'b0;
                                tx        <= START_BIT;
                                state     <= START;
                            end else begin
                                tx    <= STOP_BIT;
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        tx    <= STOP_BIT;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
